// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Two-flop synchronizer, per-press debounce FSM and chord
//                rejection for the raw push-button array. Emits a binary key
//                index with a one-cycle key_valid strobe on clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce #(
    parameter int NKEYS    = 20,
    parameter int KW       = 5,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keyin,
    output logic [KW-1:0]    keycode,
    output logic             key_valid,
    output logic             key_held,
    output logic             multi_err
);

    localparam int            c_CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE - 1);

    localparam logic [1:0] c_S_IDLE       = 2'd0;
    localparam logic [1:0] c_S_DB_PRESS   = 2'd1;
    localparam logic [1:0] c_S_PRESSED    = 2'd2;
    localparam logic [1:0] c_S_DB_RELEASE = 2'd3;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] snap_q, snap_d;
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    keycode_q, keycode_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             merr_q, merr_d;

    logic             w_s2_zero;
    logic             w_same;
    logic             w_onehot;
    logic [KW-1:0]    w_index;
    logic             w_accept;
    logic             w_release;

    assign w_s2_zero = (sync2_q == '0);
    assign w_same    = (sync2_q == snap_q);

    // Snapshot is one-hot when exactly one bit is set: clearing its lowest set bit leaves zero
    assign w_onehot  = (snap_q != '0) && ((snap_q & (snap_q - NKEYS'(1))) == '0);

    // OR-encoder over the snapshot; only meaningful when the snapshot is one-hot
    always_comb begin
        w_index = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (snap_q[i]) begin
                w_index = w_index | KW'(i);
            end
        end
    end

    // Debounce windows complete when the counter has reached its terminal value
    assign w_accept  = (state_q == c_S_DB_PRESS) && !w_s2_zero && w_same && (cnt_q == c_CNT_MAX);
    assign w_release = (state_q == c_S_DB_RELEASE) && w_s2_zero && (cnt_q == c_CNT_MAX);

    // Two-stage synchronizer for the asynchronous button levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keyin;
            sync2_q <= sync1_q;
        end
    end

    // State, debounce datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_S_IDLE;
            snap_q    <= '0;
            cnt_q     <= '0;
            keycode_q <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            keycode_q <= keycode_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            merr_q    <= merr_d;
        end
    end

    // Next-state logic: press/release debounce windows with restart on change
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_S_IDLE: begin
                if (!w_s2_zero) begin
                    snap_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = c_S_DB_PRESS;
                end
            end
            c_S_DB_PRESS: begin
                if (w_s2_zero) begin
                    state_d = c_S_IDLE;
                end else if (!w_same) begin
                    snap_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + c_CW'(1);
                end else begin
                    state_d = c_S_PRESSED;
                end
            end
            c_S_PRESSED: begin
                // Extra keys or key swaps while pressed are deliberately ignored
                if (w_s2_zero) begin
                    cnt_d   = '0;
                    state_d = c_S_DB_RELEASE;
                end
            end
            c_S_DB_RELEASE: begin
                if (!w_s2_zero) begin
                    cnt_d   = '0;
                    state_d = c_S_PRESSED;
                end else if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + c_CW'(1);
                end else begin
                    state_d = c_S_IDLE;
                end
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // Output next-values: single-cycle strobes, sticky keycode and held flag
    always_comb begin
        keycode_d = keycode_q;
        valid_d   = 1'b0;
        merr_d    = 1'b0;
        held_d    = held_q;
        if (w_accept) begin
            if (w_onehot) begin
                keycode_d = w_index;
                valid_d   = 1'b1;
                held_d    = 1'b1;
            end else begin
                merr_d    = 1'b1;
            end
        end
        if (w_release) begin
            held_d = 1'b0;
        end
    end

    assign keycode   = keycode_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign multi_err = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_keypad_debounce
//  Description : Self-checking bench for keypad_debounce: scenario table,
//                timing sequences and random stimulus against a run-length
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_debounce;

    localparam int NKEYS = 20;
    localparam int KW    = 5;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NKEYS-1:0] keyin = '0;
    logic [KW-1:0]    keycode;
    logic             key_valid;
    logic             key_held;
    logic             multi_err;

    keypad_debounce #(
        .NKEYS    (NKEYS),
        .KW       (KW),
        .DEBOUNCE (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keyin     (keyin),
        .keycode   (keycode),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The design reacts to keyin two edges late. A press
    // is accepted once the delayed level has been the same nonzero value
    // for DEB+1 consecutive samples; a release completes after DEB+1
    // consecutive zero samples. Nonzero activity while pressed only
    // breaks the zero run.
    // ------------------------------------------------------------------
    logic [NKEYS-1:0] m_hist [2];
    logic [NKEYS-1:0] m_last;
    int               m_run;
    bit               m_pressed;
    logic             m_valid, m_merr, m_held;
    logic [KW-1:0]    m_code;

    task automatic model_reset();
        m_hist[0] = '0; m_hist[1] = '0;
        m_last = '0; m_run = 0; m_pressed = 0;
        m_valid = 0; m_merr = 0; m_held = 0; m_code = '0;
    endtask

    task automatic model_edge(input logic [NKEYS-1:0] v_in);
        logic [NKEYS-1:0] v;
        v = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = v_in;
        m_valid = 0;
        m_merr  = 0;
        if (!m_pressed) begin
            if (v == '0) begin
                m_run = 0;
            end else if (m_run > 0 && v == m_last) begin
                m_run++;
            end else begin
                m_run  = 1;
                m_last = v;
            end
            if (m_run == DEB + 1) begin
                m_pressed = 1;
                m_run     = 0;
                if ($countones(v) == 1) begin
                    m_valid = 1;
                    m_held  = 1;
                    for (int i = 0; i < NKEYS; i++) if (v[i]) m_code = KW'(i);
                end else begin
                    m_merr = 1;
                end
            end
        end else begin
            if (v == '0) m_run++;
            else         m_run = 0;
            if (m_run == DEB + 1) begin
                m_pressed = 0;
                m_run     = 0;
                m_held    = 0;
            end
        end
    endtask

    int n_valid_seen;
    int n_merr_seen;
    int n_held_seen;

    // Drive one cycle of input, advance model, compare all outputs
    task automatic step(input logic [NKEYS-1:0] v);
        keyin = v;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_edge(v);
        check("key_valid", key_valid, m_valid);
        check("multi_err", multi_err, m_merr);
        check("key_held",  key_held,  m_held);
        check("keycode",   keycode,   m_code);
        check("strobe_excl", key_valid & multi_err, 0);
        if (key_valid) n_valid_seen++;
        if (multi_err) n_merr_seen++;
        if (key_held)  n_held_seen++;
    endtask

    task automatic clear_tally();
        n_valid_seen = 0;
        n_merr_seen  = 0;
        n_held_seen  = 0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        keyin = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_valid",   key_valid, 0);
        check("rst_merr",    multi_err, 0);
        check("rst_held",    key_held,  0);
        check("rst_keycode", keycode,   0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NKEYS-1:0] keys;
        int               hold;
        int               exp_valid;
        int               exp_merr;
        int               exp_code;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int vstep;
        int hstep;
        logic [NKEYS-1:0] v;
        int len;
        int r;

        // Scenario table, applied back to back after one reset
        tbl[0] = '{20'h00080, 12, 1, 0, 7};
        tbl[1] = '{20'h10000,  8, 1, 0, 16};
        tbl[2] = '{20'h00021, 10, 0, 1, 16};   // chord keeps previous keycode
        tbl[3] = '{20'h00001,  4, 0, 0, 16};   // one sample short of acceptance
        tbl[4] = '{20'h00001,  5, 1, 0, 0};    // exactly enough samples
        tbl[5] = '{20'h80000, 20, 1, 0, 19};
        tbl[6] = '{20'h00700,  6, 0, 1, 19};

        model_reset();
        do_reset();
        for (int t = 0; t < 7; t++) begin
            clear_tally();
            for (int i = 0; i < tbl[t].hold; i++) step(tbl[t].keys);
            for (int i = 0; i < 10; i++) step('0);
            check($sformatf("tbl%0d_valid", t), n_valid_seen, tbl[t].exp_valid);
            check($sformatf("tbl%0d_merr", t),  n_merr_seen,  tbl[t].exp_merr);
            check($sformatf("tbl%0d_code", t),  keycode,      tbl[t].exp_code);
            check($sformatf("tbl%0d_held", t),  key_held,     0);
        end

        // Clean press of key 7: pulse on the 7th sampling edge, held drops
        // on the 7th edge counting the first low sample as edge 1
        do_reset();
        clear_tally();
        vstep = 0;
        for (int i = 1; i <= 12; i++) begin
            step(20'h00080);
            if (key_valid && vstep == 0) vstep = i;
        end
        check("t1_latency", vstep, 7);
        check("t1_code", keycode, 7);
        hstep = 0;
        for (int i = 1; i <= 12; i++) begin
            step('0);
            if (!key_held && hstep == 0) hstep = i;
        end
        check("t1_release_edge", hstep, 7);
        check("t1_pulses", n_valid_seen, 1);

        // Bouncing press of key 3
        do_reset();
        clear_tally();
        step(20'h8); step('0); step(20'h8); step('0);
        check("t2_bounce_pulses", n_valid_seen, 0);
        vstep = 0;
        for (int i = 1; i <= 10; i++) begin
            step(20'h8);
            if (key_valid && vstep == 0) vstep = i;
        end
        check("t2_latency", vstep, 7);
        check("t2_code", keycode, 3);
        for (int i = 0; i < 10; i++) step('0);
        check("t2_pulses", n_valid_seen, 1);

        // W key with glitches during release
        do_reset();
        clear_tally();
        for (int i = 0; i < 10; i++) step(20'h10000);
        hstep = 0;
        for (int i = 1; i <= 18; i++) begin
            step((i == 3 || i == 6) ? 20'h10000 : 20'h0);
            if (!key_held && hstep == 0) hstep = i;
        end
        check("t3_held_fall", hstep, 13);
        check("t3_code", keycode, 16);
        check("t3_pulses", n_valid_seen, 1);

        // Two-key chord straight after reset
        do_reset();
        clear_tally();
        for (int i = 0; i < 10; i++) step(20'h00021);
        for (int i = 0; i < 10; i++) step('0);
        check("t4_merr", n_merr_seen, 1);
        check("t4_valid", n_valid_seen, 0);
        check("t4_code", keycode, 0);
        check("t4_held", n_held_seen, 0);

        // Reset in the middle of the press window, key still held
        do_reset();
        clear_tally();
        for (int i = 0; i < 5; i++) step(20'h00200);
        rst = 1'b1;
        #2;
        model_reset();
        check("t5_rst_valid", key_valid, 0);
        check("t5_rst_merr",  multi_err, 0);
        check("t5_rst_held",  key_held,  0);
        check("t5_rst_code",  keycode,   0);
        step(20'h00200);
        step(20'h00200);
        rst = 1'b0;
        clear_tally();
        vstep = 0;
        for (int i = 1; i <= 12; i++) begin
            step(20'h00200);
            if (key_valid && vstep == 0) vstep = i;
        end
        check("t5_latency", vstep, 7);
        check("t5_code", keycode, 9);
        check("t5_pulses", n_valid_seen, 1);

        // Extra key added while pressed is ignored
        do_reset();
        clear_tally();
        for (int i = 0; i < 8; i++)  step(20'h80000);
        for (int i = 0; i < 8; i++)  step(20'h80004);
        for (int i = 0; i < 10; i++) step('0);
        check("t6_valid", n_valid_seen, 1);
        check("t6_merr", n_merr_seen, 0);
        check("t6_code", keycode, 19);
        clear_tally();
        for (int i = 0; i < 10; i++) step(20'h00004);
        for (int i = 0; i < 10; i++) step('0);
        check("t6_second_valid", n_valid_seen, 1);
        check("t6_second_code", keycode, 2);

        // Random bursts of held levels checked cycle by cycle
        do_reset();
        for (int blk = 0; blk < 80; blk++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      v = '0;
            else if (r < 8) v = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
            else            v = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) |
                                (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) step(v);
        end
        for (int i = 0; i < 12; i++) step('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
